// File: rtl/cpu_step_ctrl_if.sv
// Core-side link of the execution sequencer: the commit strobe out, halt/PC/breakpoint in.
interface cpu_step_ctrl_if #(
  parameter int PC_W = 16
);
  // step_en is a bare one-cycle strobe with no ready: the core commits exactly one
  // instruction on every cycle it is high; all other signals are plain levels.
  logic            step_en;
  logic            cpu_halt;
  logic [PC_W-1:0] cpu_pc;
  logic            brk_en;
  logic [PC_W-1:0] brk_pc;

  modport master (
    output step_en,
    input  cpu_halt,
    input  cpu_pc,
    input  brk_en,
    input  brk_pc
  );

  modport slave (
    input  step_en,
    output cpu_halt,
    output cpu_pc,
    output brk_en,
    output brk_pc
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer: one-cycle step_en commit pulses for free-run, single-step and sticky halt.
// Define STEP_CTRL_BRK_EN to compile in the stop-on-PC breakpoint in RUN.
module cpu_step_ctrl #(
  parameter int TICK_CYCLES = 67108864,
  parameter int DEB_CYCLES  = 1000000,
  parameter int PC_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_sw,
  input  logic            step_key,
  cpu_step_ctrl_if.master core,
  output logic [1:0]      state_o,
  output logic            halted_led,
  output logic [15:0]     step_count
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int DEB_W  = $clog2(DEB_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              run_meta, run_sync;
  logic              key_meta, key_sync;
  logic              key_deb, key_deb_q;
  logic              press;
  logic [DEB_W-1:0]  deb_cnt;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_d;
  logic              tick;
  logic              brk_hit;
  logic              step_en_d;
  logic [PC_W-1:0]   brk_pc_w;

  // Board inputs are asynchronous; the key idles high (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      run_meta <= run_sw;
      run_sync <= run_meta;
      key_meta <= step_key;
      key_sync <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      key_deb   <= 1'b1;
      key_deb_q <= 1'b1;
    end else begin
      key_deb_q <= key_deb;
      if (key_sync == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        key_deb <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = key_deb_q & ~key_deb;
  assign tick  = (state_q == RUN) && (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign brk_pc_w = core.brk_pc;

`ifdef STEP_CTRL_BRK_EN
  assign brk_hit = core.brk_en && (core.cpu_pc == brk_pc_w);
`else
  logic unused_brk;
  assign unused_brk = ^{core.brk_en, core.cpu_pc, brk_pc_w};
  assign brk_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    step_en_d  = 1'b0;
    tick_cnt_d = '0;
    if (core.cpu_halt) begin
      state_d = HALT;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_sync) begin
            state_d = RUN;
          end else if (press) begin
            state_d   = STEP;
            step_en_d = 1'b1;
          end
        end
        RUN: begin
          if (!run_sync) begin
            state_d = IDLE;
          end else if (tick && brk_hit) begin
            state_d = IDLE;
          end else begin
            step_en_d  = tick;
            tick_cnt_d = tick ? '0 : tick_cnt + 1'b1;
          end
        end
        STEP:    state_d = IDLE;
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt     <= '0;
      core.step_en <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt     <= tick_cnt_d;
      core.step_en <= step_en_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
    end else if (core.step_en && (step_count != 16'hFFFF)) begin
      step_count <= step_count + 16'd1;
    end
  end

  assign state_o    = state_q;
  assign halted_led = (state_q == HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with TICK_CYCLES=8, DEB_CYCLES=4: vector table plus corner-case sequences.
module tb_cpu_step_ctrl;

  localparam int W = 34;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_HALT = 2'b11;

  typedef struct packed {
    logic        run_sw;
    logic        step_key;
    logic        cpu_halt;
    logic [7:0]  hold;
    logic [3:0]  n_pulses;
    logic [1:0]  pulse_state;
    logic [7:0]  first_off;
    logic [1:0]  exp_state;
    logic [15:0] exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw;
  logic        step_key;
  logic [1:0]  state_o;
  logic        halted_led;
  logic [15:0] step_count;

  cpu_step_ctrl_if #(.PC_W(16)) core_if ();

  cpu_step_ctrl #(
    .TICK_CYCLES(8),
    .DEB_CYCLES (4),
    .PC_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_sw    (run_sw),
    .step_key  (step_key),
    .core      (core_if),
    .state_o   (state_o),
    .halted_led(halted_led),
    .step_count(step_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_cnt = 16'd0;
  logic [W-1:0] exp_q[$];
  vec_t        vecs[11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [15:0] cnt, input int c);
    logic [31:0] cu;
    cu = c;
    return {st, cnt, cu[15:0]};
  endfunction

  // driver tasks
  task automatic expect_pulse(input logic [1:0] st, input int at);
    exp_q.push_back(mk(st, model_cnt, at));
    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
  endtask

  task automatic check_drained(input string name);
    check(name, W'(exp_q.size()), W'(0));
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    model_cnt = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_key();
    int s;
    s        = cyc;
    step_key = 1'b0;
    expect_pulse(S_STEP, s + 7);
    repeat (10) @(negedge clk);
    step_key = 1'b1;
    repeat (10) @(negedge clk);
    check("press_state", W'(state_o), W'(S_IDLE));
    check_drained("press_pulses");
  endtask

  // scoreboard monitor: every step_en pulse pops one expected {state, count, cycle}
  logic prev_en = 1'b0;
  int   last_run_cyc = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en      <= 1'b0;
      last_run_cyc <= -1;
    end else begin
      if (core_if.step_en) begin
        check("no_back_to_back", W'(prev_en), W'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got pulse state %0d count %0h at cycle %0d, expected none",
                   state_o, step_count, cyc);
        end else begin
          check("pulse", {state_o, step_count, cyc[15:0]}, exp_q.pop_front());
        end
        if (state_o == S_RUN) begin
          if (last_run_cyc >= 0) check("run_spacing", W'(cyc - last_run_cyc), W'(8));
          last_run_cyc <= cyc;
        end
      end else if (state_o != S_RUN) begin
        last_run_cyc <= -1;
      end
      prev_en <= core_if.step_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000 ns");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $finish;
  end

  initial begin
    int   s;
    logic found;
    vec_t v;

    //        run  key  halt hold   np    pst     off    est     count
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd6,  4'd0, S_IDLE, 8'd0,  S_IDLE, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd40, 4'd4, S_RUN,  8'd11, S_RUN,  16'd4};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd6,  4'd0, S_IDLE, 8'd0,  S_IDLE, 16'd4};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd12, 4'd1, S_STEP, 8'd7,  S_IDLE, 16'd5};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd12, 4'd0, S_IDLE, 8'd0,  S_IDLE, 16'd5};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd20, 4'd2, S_RUN,  8'd11, S_RUN,  16'd7};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd8,  4'd0, S_IDLE, 8'd0,  S_IDLE, 16'd7};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'd6,  4'd0, S_IDLE, 8'd0,  S_RUN,  16'd7};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'd1,  4'd0, S_IDLE, 8'd0,  S_HALT, 16'd7};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd12, 4'd0, S_IDLE, 8'd0,  S_HALT, 16'd7};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd12, 4'd0, S_IDLE, 8'd0,  S_HALT, 16'd7};

    run_sw           = 1'b0;
    step_key         = 1'b1;
    core_if.cpu_halt = 1'b0;
    core_if.cpu_pc   = 16'h0000;
    core_if.brk_en   = 1'b0;
    core_if.brk_pc   = 16'h0000;
    do_reset();

    check("reset_state", W'(state_o), W'(S_IDLE));
    check("reset_step_en", W'(core_if.step_en), W'(0));
    check("reset_count", W'(step_count), W'(0));
    check("reset_led", W'(halted_led), W'(0));

    for (int i = 0; i < 11; i++) begin
      v                = vecs[i];
      run_sw           = v.run_sw;
      step_key         = v.step_key;
      core_if.cpu_halt = v.cpu_halt;
      s                = cyc;
      for (int p = 0; p < int'(v.n_pulses); p++)
        expect_pulse(v.pulse_state, s + int'(v.first_off) + p * 8);
      repeat (int'(v.hold)) @(negedge clk);
      check($sformatf("vec%0d_state", i), W'(state_o), W'(v.exp_state));
      check($sformatf("vec%0d_count", i), W'(step_count), W'(v.exp_count));
      check($sformatf("vec%0d_led", i), W'(halted_led), W'(v.exp_state == S_HALT));
      check_drained($sformatf("vec%0d_pulses", i));
    end
    core_if.cpu_halt = 1'b0;
    run_sw           = 1'b0;
    step_key         = 1'b1;

    // reset is the only way out of HALT
    do_reset();
    check("halt_reset_state", W'(state_o), W'(S_IDLE));
    check("halt_reset_count", W'(step_count), W'(0));
    check("halt_reset_led", W'(halted_led), W'(0));

    // bouncing key: 0,1,0 then held low -> one press
    s        = cyc;
    step_key = 1'b0;
    @(negedge clk);
    step_key = 1'b1;
    @(negedge clk);
    step_key = 1'b0;
    expect_pulse(S_STEP, s + 9);
    repeat (6) @(negedge clk);
    check("bounce_pre_state", W'(state_o), W'(S_IDLE));
    step_key = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_state", W'(state_o), W'(S_IDLE));
    check("bounce_count", W'(step_count), W'(1));
    check_drained("bounce_pulses");

    // breakpoint at the first tick of a run
    core_if.brk_en = 1'b1;
    core_if.brk_pc = 16'h0005;
    core_if.cpu_pc = 16'h0005;
    s              = cyc;
    run_sw         = 1'b1;
`ifndef STEP_CTRL_BRK_EN
    expect_pulse(S_RUN, s + 11);
`endif
    repeat (9) @(negedge clk);
    run_sw = 1'b0;
    repeat (6) @(negedge clk);
    check("brk_state", W'(state_o), W'(S_IDLE));
    check_drained("brk_pulses");
    press_key();
    core_if.brk_en = 1'b0;

    // saturation of step_count
    force dut.step_count = 16'hFFFE;
    @(negedge clk);
    release dut.step_count;
    model_cnt = 16'hFFFE;
    @(negedge clk);
    check("sat_preload", W'(step_count), W'(16'hFFFE));
    for (int k = 0; k < 3; k++) press_key();
    check("sat_count", W'(step_count), W'(16'hFFFF));

    // reset while step_en is high
    do_reset();
    s        = cyc;
    step_key = 1'b0;
    expect_pulse(S_STEP, s + 7);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (core_if.step_en) found = 1'b1;
    end
    check("mid_pulse_seen", W'(found), W'(1));
    #1;
    step_key = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("mid_pulse_step_en", W'(core_if.step_en), W'(0));
    check("mid_pulse_state", W'(state_o), W'(S_IDLE));
    check("mid_pulse_count", W'(step_count), W'(0));
    model_cnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_state", W'(state_o), W'(S_IDLE));
    check("post_reset_count", W'(step_count), W'(0));
    check_drained("post_reset_pulses");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Execution sequencer for the 16-bit CPU core. Generates one-cycle `step_en` pulses that let the core commit one instruction. Supports free-run at a slow, human-visible rate, single-step from a pushbutton, and a sticky halt when the core reports an unrecognized opcode. Sits between board inputs (switch, key) and the core's commit enable; it replaces the core's free-running count-based pacing.

Parameters:
TICK_CYCLES, 67108864, clk cycles between step pulses in RUN (2^26 at 50 MHz, about 1.34 s); minimum 2.
DEB_CYCLES, 1000000, cycles `step_key` must be stable before its new level is accepted (20 ms); minimum 1.
PC_W, 16, width of `cpu_pc` and `brk_pc`.

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
run_sw  in  1  run switch, asynchronous level; 1 = free-run
step_key  in  1  single-step pushbutton, asynchronous, active-low, bouncy
cpu_halt  in  1  core reports unrecognized instruction, level
cpu_pc  in  PC_W  core's current PC
brk_en  in  1  breakpoint enable
brk_pc  in  PC_W  breakpoint address
step_en  out  1  one-cycle commit pulse to the core
state_o  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT
halted_led  out  1  1 while in HALT
step_count  out  16  number of `step_en` pulses issued, saturating

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; `step_en` = 0; `step_count` = 0; `halted_led` = 0.
  - Tick counter = 0; debounce counter = 0; debounced key = 1.
  - Reset mid-pulse drops `step_en` immediately.
- Input sync:
  - `run_sw` and `step_key` each pass through a 2-flop synchronizer.
  - `cpu_halt`, `cpu_pc` and `brk_*` are synchronous to `clk` and are used directly.
- Debounce:
  - Counter resets to 0 whenever the synced key equals the debounced key; otherwise it increments.
  - At DEB_CYCLES-1 the debounced key takes the synced value and the counter clears.
  - `press` = one-cycle pulse on the debounced 1->0 transition.
- Tick counter:
  - Runs only in RUN. Counts 0..TICK_CYCLES-1, then wraps to 0.
  - `tick` is asserted when count == TICK_CYCLES-1.
  - Cleared on every entry to RUN and in all other states.
- FSM transitions, evaluated each cycle, in priority order:
  - Any state, `cpu_halt`=1 -> HALT. HALT is sticky; only `rst_n` exits it.
  - IDLE: `run_sync`=1 -> RUN. Else `press` -> STEP. Run wins if both occur in the same cycle.
  - RUN: `run_sync`=0 -> IDLE with no pulse that cycle. Else breakpoint hit on `tick` -> IDLE with no pulse (see Optional Feature). Else `tick` -> `step_en`=1 next cycle, stay in RUN.
  - STEP: `step_en`=1 for exactly this one cycle, then IDLE unconditionally. `press` is ignored in RUN and STEP.
- Outputs:
  - `step_en` is registered. Latency from the `tick`/`press` cycle to `step_en` = 1 cycle.
  - Never more than one `step_en` per TICK_CYCLES cycles in RUN.
  - Never two consecutive `step_en` cycles.
  - `step_count` increments on each `step_en` cycle and saturates at 16'hFFFF (no wrap).
  - `state_o` is the registered state encoding; `halted_led` = (state == HALT).
  - No `step_en` is ever asserted in HALT or IDLE.

Optional Feature:
STEP_CTRL_BRK_EN
- Defined:
  - In RUN, a `tick` with `brk_en`=1 and `cpu_pc`==`brk_pc` suppresses the pulse and moves to IDLE.
  - A subsequent single-step from IDLE executes the breakpoint instruction. The breakpoint is not re-checked in STEP.
- Undefined: `brk_en` and `brk_pc` are ignored (no logic is generated); RUN never stops on a PC match.

Test Plan (bench uses TICK_CYCLES=8, DEB_CYCLES=4):
- Reset, then `run_sw`=1 for 40 cycles -> state 01, `step_en` pulses spaced exactly 8 cycles apart, first pulse 2+1+8 cycles after `run_sw` rises; `step_count`=4 or 5 accordingly.
- IDLE, `step_key` bouncing 0/1 every cycle for 3 cycles then held 0 for 6 cycles -> exactly one `step_en`, state sequence 00->10->00, `step_count`=1.
- RUN, `cpu_halt`=1 for 1 cycle -> state 11, `halted_led`=1. Toggling `run_sw` and pressing the key then produces no `step_en`. Asserting `rst_n`=0 clears state to 00 and `step_count` to 0.
- With STEP_CTRL_BRK_EN: `brk_en`=1, `brk_pc`=16'h0005, `cpu_pc`=5 at a tick -> no pulse, state 00. A key press then yields one `step_en`. Without the macro, the same stimulus keeps pulsing.
- `step_count` preloaded near saturation by forcing 16'hFFFE, then 3 steps -> reads 16'hFFFF.
- `rst_n` asserted in the same cycle as `step_en` -> `step_en` falls asynchronously. After release, no pulse is issued until the next `tick`/`press`.
